// File: rtl/m72_irq_sched_pkg.sv
// m72_pkg: shared types and constants for the m72 interrupt scheduler.
//   irq_state_t  - interrupt handshake state machine encoding
//   REG_*        - CPU register select codes on ADDR
//   LVL_*        - interrupt level numbers placed in VEC[2:0]
package m72_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

  localparam logic [2:0] REG_RLO   = 3'd0;
  localparam logic [2:0] REG_RHI   = 3'd1;
  localparam logic [2:0] REG_MASK  = 3'd2;
  localparam logic [2:0] REG_VBASE = 3'd3;
  localparam logic [2:0] REG_EOI   = 3'd4;

  localparam logic [2:0] LVL_VBLK  = 3'd0;
  localparam logic [2:0] LVL_HINT  = 3'd1;
  localparam logic [2:0] LVL_SPUR  = 3'd7;

endpackage

// File: rtl/m72_rise_det.sv
// m72_rise_det: per-bit registered rising-edge detector.
//   CLK_32M  in   system clock
//   RESET_N  in   synchronous active-low reset
//   level    in   W level inputs
//   rise     out  W one-cycle pulses, registered, one per 0->1 transition
module m72_rise_det #(
  parameter int W = 2
) (
  input  logic         CLK_32M,
  input  logic         RESET_N,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  // History is loaded with the live level during reset so that a source
  // already high when reset is released does not look like a new edge.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      prev <= level;
      rise <= '0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

// File: rtl/m72_irq_sched.sv
// m72_irq_sched: interrupt scheduler and raster-IRQ configurator sitting
// between the video timing generator and the V30 bus glue.
//   CLK_32M   in   system clock
//   RESET_N   in   synchronous active-low reset
//   WR/ADDR/DIN in CPU register write (0 rlo, 1 rhi, 2 mask, 3 vbase, 4 EOI)
//   VBLK/HINT in   interrupt source levels from the timing block
//   ISET, ISET_A0, ISET_D out  raster register write stroke to the timing block
//   INTR      out  interrupt request to the CPU
//   INTA      in   interrupt-acknowledge pulse
//   VEC, VEC_VALID out  interrupt vector and its one-cycle strobe
module m72_irq_sched
  import m72_pkg::*;
#(
  parameter logic [7:0] VEC_BASE_RST = 8'h20,
  parameter logic [1:0] MASK_RST     = 2'b11
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        WR,
  input  logic [2:0]  ADDR,
  input  logic [7:0]  DIN,
  input  logic        VBLK,
  input  logic        HINT,
  output logic        ISET,
  output logic        ISET_A0,
  output logic [15:0] ISET_D,
  output logic        INTR,
  input  logic        INTA,
  output logic [7:0]  VEC,
  output logic        VEC_VALID
);

  irq_state_t state, state_nxt;

  logic [1:0] src_edge;
  logic [1:0] pending;
  logic [1:0] mask;
  logic [4:0] vbase;
  logic       in_service;
  logic [1:0] req;
  logic [1:0] clr;
  logic       take;
  logic [2:0] lvl;
  logic       wr_raster;
  logic       wr_eoi;

  m72_rise_det #(.W(2)) u_rise_det (
    .CLK_32M (CLK_32M),
    .RESET_N (RESET_N),
    .level   ({HINT, VBLK}),
    .rise    (src_edge)
  );

  assign wr_raster = WR && ((ADDR == REG_RLO) || (ADDR == REG_RHI));
  assign wr_eoi    = WR && (ADDR == REG_EOI);

  // The fresh edge is folded into the request so the FSM reacts in the same
  // cycle the edge register fires, keeping edge-to-INTR at two clocks.
  assign req  = (pending | src_edge) & ~mask;
  assign INTR = (state == REQ) && (|req);

  always_comb begin
    state_nxt = state;
    clr       = 2'b00;
    take      = 1'b0;
    lvl       = LVL_SPUR;
    if (req[0])
      lvl = LVL_VBLK;
    else if (req[1])
      lvl = LVL_HINT;
    case (state)
      IDLE:    if ((|req) && !in_service) state_nxt = REQ;
      REQ: begin
        if (req == 2'b00) begin
          state_nxt = IDLE;
        end else if (INTA) begin
          take      = 1'b1;
          clr       = (lvl == LVL_VBLK) ? 2'b01 : 2'b10;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = SERVICE;
      SERVICE: if (wr_eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A new edge on a bit being cleared this cycle keeps the bit set.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      state      <= IDLE;
      pending    <= 2'b00;
      in_service <= 1'b0;
      mask       <= MASK_RST;
      vbase      <= VEC_BASE_RST[7:3];
      ISET       <= 1'b0;
      ISET_A0    <= 1'b0;
      ISET_D     <= 16'h0000;
      VEC        <= 8'h00;
      VEC_VALID  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~clr) | src_edge;

      if (take)
        in_service <= 1'b1;
      else if (wr_eoi)
        in_service <= 1'b0;

      if (WR && (ADDR == REG_MASK))
        mask <= DIN[1:0];
      if (WR && (ADDR == REG_VBASE))
        vbase <= DIN[7:3];

      ISET <= wr_raster;
      if (wr_raster) begin
        ISET_A0 <= ADDR[0];
        ISET_D  <= {8'h00, DIN};
      end

      // Any INTA that does not win an arbitration in REQ gets the spurious vector.
      VEC_VALID <= INTA;
      if (INTA)
        VEC <= take ? {vbase, lvl} : {vbase, LVL_SPUR};
    end
  end

endmodule

// File: tb/tb_m72_irq_sched.sv
// tb_m72_irq_sched: directed self-checking bench for m72_irq_sched.
module tb_m72_irq_sched;

  logic        CLK_32M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        WR = 1'b0;
  logic [2:0]  ADDR = 3'd0;
  logic [7:0]  DIN = 8'h00;
  logic        VBLK = 1'b0;
  logic        HINT = 1'b0;
  logic        INTA = 1'b0;
  logic        ISET;
  logic        ISET_A0;
  logic [15:0] ISET_D;
  logic        INTR;
  logic [7:0]  VEC;
  logic        VEC_VALID;

  int checks = 0;
  int failures = 0;

  m72_irq_sched dut (
    .CLK_32M   (CLK_32M),
    .RESET_N   (RESET_N),
    .WR        (WR),
    .ADDR      (ADDR),
    .DIN       (DIN),
    .VBLK      (VBLK),
    .HINT,
    .ISET      (ISET),
    .ISET_A0   (ISET_A0),
    .ISET_D    (ISET_D),
    .INTR      (INTR),
    .INTA      (INTA),
    .VEC       (VEC),
    .VEC_VALID (VEC_VALID)
  );

  always #5 CLK_32M = ~CLK_32M;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DIN = d;
    tick();
    WR = 1'b0;
  endtask

  task automatic pulse_inta();
    INTA = 1'b1;
    tick();
    INTA = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL reset_intr: got %b want 0", INTR); end
    checks++; if (ISET !== 1'b0 || ISET_D !== 16'h0000 || ISET_A0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_iset: got %b/%b/%h want 0/0/0000", ISET, ISET_A0, ISET_D); end
    checks++; if (VEC !== 8'h00 || VEC_VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_vec: got %h/%b want 00/0", VEC, VEC_VALID); end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_raster();
    WR = 1'b1; ADDR = 3'd0; DIN = 8'h7F;
    tick();
    ADDR = 3'd1; DIN = 8'h01;
    checks++; if (ISET !== 1'b1 || ISET_A0 !== 1'b0 || ISET_D !== 16'h007F) begin failures++; $display("[TB] FAIL raster_lo: got %b/%b/%h want 1/0/007f", ISET, ISET_A0, ISET_D); end
    tick();
    WR = 1'b0;
    checks++; if (ISET !== 1'b1 || ISET_A0 !== 1'b1 || ISET_D !== 16'h0001) begin failures++; $display("[TB] FAIL raster_hi: got %b/%b/%h want 1/1/0001", ISET, ISET_A0, ISET_D); end
    tick();
    checks++; if (ISET !== 1'b0) begin failures++; $display("[TB] FAIL raster_end: ISET got %b want 0", ISET); end
    write_reg(3'd2, 8'h01);
    checks++; if (ISET !== 1'b0) begin failures++; $display("[TB] FAIL raster_mask_wr: ISET got %b want 0", ISET); end
  endtask

  task automatic test_vblk();
    write_reg(3'd2, 8'h00);
    VBLK = 1'b1;
    tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL vblk_early: INTR got %b want 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL vblk_intr: INTR got %b want 1", INTR); end
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h20) begin failures++; $display("[TB] FAIL vblk_vec: got %b/%h want 1/20", VEC_VALID, VEC); end
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL vblk_ack_intr: INTR got %b want 0", INTR); end
    tick();
    checks++; if (VEC_VALID !== 1'b0) begin failures++; $display("[TB] FAIL vblk_strobe: VEC_VALID got %b want 0", VEC_VALID); end
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL vblk_service: INTR got %b want 0", INTR); end
    VBLK = 1'b0;
    write_reg(3'd4, 8'h00);
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL vblk_after_eoi: INTR got %b want 0", INTR); end
  endtask

  task automatic test_both();
    write_reg(3'd3, 8'h40);
    VBLK = 1'b1; HINT = 1'b1;
    tick(); tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL both_intr: INTR got %b want 1", INTR); end
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h40) begin failures++; $display("[TB] FAIL both_vec1: got %b/%h want 1/40", VEC_VALID, VEC); end
    tick();
    write_reg(3'd4, 8'h00);
    tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL both_rereq: INTR got %b want 1", INTR); end
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h41) begin failures++; $display("[TB] FAIL both_vec2: got %b/%h want 1/41", VEC_VALID, VEC); end
    tick();
    write_reg(3'd4, 8'h00);
    VBLK = 1'b0; HINT = 1'b0;
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL both_idle: INTR got %b want 0", INTR); end
  endtask

  task automatic test_mask();
    write_reg(3'd2, 8'h02);
    HINT = 1'b1;
    tick(); tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL mask_blocked: INTR got %b want 0", INTR); end
    write_reg(3'd2, 8'h00);
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL mask_unmask_early: INTR got %b want 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL mask_unmask: INTR got %b want 1", INTR); end
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h41) begin failures++; $display("[TB] FAIL mask_vec: got %b/%h want 1/41", VEC_VALID, VEC); end
    tick();
    write_reg(3'd4, 8'h00);
    HINT = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    HINT = 1'b1;
    tick(); tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL prio_hint_req: INTR got %b want 1", INTR); end
    VBLK = 1'b1;
    tick(); tick();
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h40) begin failures++; $display("[TB] FAIL prio_vblk_wins: got %b/%h want 1/40", VEC_VALID, VEC); end
    HINT = 1'b0; VBLK = 1'b0;
    tick();
    write_reg(3'd4, 8'h00);
    tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL prio_hint_rereq: INTR got %b want 1", INTR); end
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h41) begin failures++; $display("[TB] FAIL prio_hint_vec: got %b/%h want 1/41", VEC_VALID, VEC); end
    tick();
    write_reg(3'd4, 8'h00);
    tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL prio_once: INTR got %b want 0", INTR); end
  endtask

  task automatic test_spurious();
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h47) begin failures++; $display("[TB] FAIL spur_vec: got %b/%h want 1/47", VEC_VALID, VEC); end
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL spur_intr: INTR got %b want 0", INTR); end
    tick();
  endtask

  task automatic test_reset_mid();
    VBLK = 1'b1;
    tick(); tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_req: INTR got %b want 1", INTR); end
    RESET_N = 1'b0;
    tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_intr: INTR got %b want 0", INTR); end
    RESET_N = 1'b1;
    tick();
    write_reg(3'd2, 8'h00);
    tick(); tick(); tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_pending: INTR got %b want 0", INTR); end
    pulse_inta();
    checks++; if (VEC_VALID !== 1'b1 || VEC !== 8'h27) begin failures++; $display("[TB] FAIL rst_mid_vbase: got %b/%h want 1/27", VEC_VALID, VEC); end
    VBLK = 1'b0;
    tick();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_raster();
    test_vblk();
    test_both();
    test_mask();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
